// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one single-cycle ALU. Round-robin grant,
// per-requester registered response (result + {C,V,Z,N}) with valid/ready.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req 0 wins).
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [2:0]         req0_ctrl,
    input  logic [2:0]         req1_ctrl,
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [WIDTH-1:0]   rsp0_result,
    output logic [WIDTH-1:0]   rsp1_result,
    output logic [3:0]         rsp0_flags,
    output logic [3:0]         rsp1_flags
);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               rsp_vld [NUM_REQ];
    logic [WIDTH-1:0]   rsp_res [NUM_REQ];
    logic [3:0]         rsp_flg [NUM_REQ];

    // a slot draining this cycle is as good as empty
    assign elig      = req_valid & (~rsp_valid | rsp_ready);
    assign req_ready = grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // requester 0 always wins; requester 1 only gets idle slots
    always_comb begin
        grant    = '0;
        grant[0] = elig[0];
        grant[1] = elig[1] & ~elig[0];
    end
`else
    logic last_grant;

    // round-robin: on contention, grant whoever did not win last time
    always_comb begin
        grant = elig;
        if (elig == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    // pointer moves only when someone was actually granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end
`endif

    // shared ALU, inputs default to requester 0 when idle
    logic [WIDTH-1:0] alu_a, alu_b, alu_bx, alu_res;
    logic [2:0]       alu_ctrl;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             ovf_raw, carry, ovf;
    logic [3:0]       alu_flags;

    assign alu_a    = grant[1] ? req1_a    : req0_a;
    assign alu_b    = grant[1] ? req1_b    : req0_b;
    assign alu_ctrl = grant[1] ? req1_ctrl : req0_ctrl;

    // ctrl[0] selects subtract (two's complement of B) for sub and slt
    assign alu_bx   = alu_ctrl[0] ? ~alu_b : alu_b;
    assign sum_full = {1'b0, alu_a} + {1'b0, alu_bx} + {{WIDTH{1'b0}}, alu_ctrl[0]};
    assign sum      = sum_full[WIDTH-1:0];
    assign ovf_raw  = ~(alu_a[WIDTH-1] ^ alu_b[WIDTH-1] ^ alu_ctrl[0]) &
                       (alu_a[WIDTH-1] ^ sum[WIDTH-1]);
    // carry/overflow only reported on the adder codes (ctrl[1]=0)
    assign carry    = ~alu_ctrl[1] & sum_full[WIDTH];
    assign ovf      = ~alu_ctrl[1] & ovf_raw;

    // result select; undefined codes yield zero
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            3'b000, 3'b001: alu_res = sum;
            3'b010:         alu_res = alu_a & alu_b;
            3'b011:         alu_res = alu_a | alu_b;
            3'b101:         alu_res = {{(WIDTH-1){1'b0}}, ovf_raw ^ sum[WIDTH-1]};
            default:        alu_res = '0;
        endcase
    end

    assign alu_flags = {carry, ovf, (alu_res == '0), alu_res[WIDTH-1]};

    // per-requester response slots: load on grant, clear on drain, else hold
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_vld[i] <= 1'b0;
                rsp_res[i] <= '0;
                rsp_flg[i] <= '0;
            end else if (grant[i]) begin
                rsp_vld[i] <= 1'b1;
                rsp_res[i] <= alu_res;
                rsp_flg[i] <= alu_flags;
            end else if (rsp_ready[i]) begin
                rsp_vld[i] <= 1'b0;
            end
        end
    end

    assign rsp_valid   = {rsp_vld[1], rsp_vld[0]};
    assign rsp0_result = rsp_res[0];
    assign rsp1_result = rsp_res[1];
    assign rsp0_flags  = rsp_flg[0];
    assign rsp1_flags  = rsp_flg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks plus randomized traffic; a reference model
// predicts grants and pushes expected responses, a monitor pops and compares.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
    } item_t;

    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  req_valid = 0, req_ready, rsp_valid, rsp_ready = 2'b11;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;

    int n_chk = 0;
    int n_fail = 0;

    alu_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_flags(rsp0_flags), .rsp1_flags(rsp1_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU behaviour from arithmetic definitions; flags {C,V,Z,N}
    function automatic item_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        item_t  it;
        longint sa, sb, r;
        logic   cy, ov;
        logic [32:0] s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        it.res = 0; cy = 0; ov = 0;
        case (c)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; it.res = s[31:0]; cy = s[32];
                        r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd1: begin it.res = a - b; cy = (a >= b);
                        r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd2: it.res = a & b;
            3'd3: it.res = a | b;
            3'd5: begin it.res = (sa < sb) ? 32'd1 : 32'd0; cy = (a >= b);
                        r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd4: begin s = {1'b0, a} + {1'b0, b}; cy = s[32];
                        r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            default: ;
        endcase
        it.fl = {cy, ov, (it.res == 0), it.res[31]};
        return it;
    endfunction

    // reference model state
    item_t      q0[$], q1[$];
    item_t      pend0, pend1;
    logic [1:0] exp_g = 0, rr_s = 0, m_rv = 0, elig;
    logic       m_last = 1;

    // predict this cycle's grant and the responses it will produce
    always @(negedge clk) begin
        if (rst) begin
            exp_g = 0;
        end else begin
            elig = req_valid & (~m_rv | rsp_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = {elig[1] & ~elig[0], elig[0]};
`else
            if (elig == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
            else               exp_g = elig;
`endif
            chk("grant", {30'd0, req_ready}, {30'd0, exp_g});
            if (exp_g[0]) pend0 = model(req0_ctrl, req0_a, req0_b);
            if (exp_g[1]) pend1 = model(req1_ctrl, req1_a, req1_b);
        end
        rr_s = rsp_ready;
    end

    // commit predicted grants at the clock edge
    always @(posedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete();
            m_rv = 0; m_last = 1; exp_g = 0;
        end else begin
            if (exp_g[0]) q0.push_back(pend0);
            if (exp_g[1]) q1.push_back(pend1);
            for (int i = 0; i < 2; i++)
                m_rv[i] = exp_g[i] ? 1'b1 : (rr_s[i] ? 1'b0 : m_rv[i]);
            if (|exp_g) m_last = exp_g[1];
        end
    end

    // monitor: compare presented responses with the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", {30'd0, rsp_valid}, 32'd0);
        end else begin
            if (q0.size() > 2 || q1.size() > 2) chk("sb_depth", 32'd1, 32'd0);
            if (q0.size() > 1) void'(q0.pop_front());
            if (q1.size() > 1) void'(q1.pop_front());
            chk("rsp0_valid", {31'd0, rsp_valid[0]}, {31'd0, q0.size() != 0});
            chk("rsp1_valid", {31'd0, rsp_valid[1]}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) begin
                chk("rsp0_result", rsp0_result, q0[0].res);
                chk("rsp0_flags", {28'd0, rsp0_flags}, {28'd0, q0[0].fl});
                if (rsp_ready[0]) void'(q0.pop_front());
            end
            if (q1.size() != 0) begin
                chk("rsp1_result", rsp1_result, q1[0].res);
                chk("rsp1_flags", {28'd0, rsp1_flags}, {28'd0, q1[0].fl});
                if (rsp_ready[1]) void'(q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [1:0] cont_exp [4];

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        // reset values
        #1 rst = 1;
        #1;
        chk("reset_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_res0", rsp0_result, 32'd0);
        chk("reset_res1", rsp1_result, 32'd0);
        chk("reset_flags", {24'd0, rsp1_flags, rsp0_flags}, 32'd0);
        step(); step();
        rst = 0;

        // req0 add
        step();
        req0_a = 32'h5; req0_b = 32'h7; req0_ctrl = 3'b000; req_valid = 2'b01;
        step(); req_valid = 0;
        @(negedge clk);
        chk("add_res", rsp0_result, 32'h0000000C);
        chk("add_flags", {28'd0, rsp0_flags}, 32'h0);
        chk("add_valid", {30'd0, rsp_valid}, 32'h1);

        // req1 sub with signed overflow
        step();
        req1_a = 32'h80000000; req1_b = 32'h1; req1_ctrl = 3'b001; req_valid = 2'b10;
        step(); req_valid = 0;
        @(negedge clk);
        chk("sub_res", rsp1_result, 32'h7FFFFFFF);
        chk("sub_flags", {28'd0, rsp1_flags}, 32'hC);

        // req1 slt signed
        step();
        req1_a = 32'hFFFFFFFF; req1_b = 32'h1; req1_ctrl = 3'b101; req_valid = 2'b10;
        step(); req_valid = 0;
        @(negedge clk);
        chk("slt_res", rsp1_result, 32'h1);
        chk("slt_flags", {28'd0, rsp1_flags}, 32'h8);

        // undefined ctrl code
        step();
        req0_a = 32'h12345678; req0_b = 32'h9; req0_ctrl = 3'b111; req_valid = 2'b01;
        step(); req_valid = 0;
        @(negedge clk);
        chk("undef_res", rsp0_result, 32'h0);
        chk("undef_flags", {28'd0, rsp0_flags}, 32'h2);

        // reset the cycle after a req0 grant
        step();
        req0_a = 32'h1; req0_b = 32'h2; req0_ctrl = 3'b000; req_valid = 2'b01;
        step(); req_valid = 0; rst = 1;
        #1;
        chk("midrst_valid", {30'd0, rsp_valid}, 32'h0);
        chk("midrst_res0", rsp0_result, 32'h0);
        step(); rst = 0;

        // contention from reset
        req0_a = 32'h10; req0_b = 32'h20; req0_ctrl = 3'b000;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 3'b011;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contention", {30'd0, req_ready}, {30'd0, cont_exp[k]});
            step();
        end

        // backpressure on slot 0
        rsp_ready = 2'b10;
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", {30'd0, req_ready}, 32'h2);
            chk("bp_hold", rsp0_result, 32'h30);
            step();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_release", {31'd0, req_ready[0]}, 32'h1);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            req0_b = $urandom; req1_b = $urandom;
            req0_a = ($urandom_range(0, 5) == 0) ? req0_b : $urandom;
            req1_a = ($urandom_range(0, 5) == 0) ? req1_b : $urandom;
            req0_ctrl = 3'($urandom); req1_ctrl = 3'($urandom);
            step();
        end
        req_valid = 0;
        rsp_ready = 2'b11;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
